// File: rtl/lcd_bus_scheduler.sv
// HD44780-style LCD bus scheduler.
// Runs the power-up wait and the fixed init sequence. After that it arbitrates
// round-robin between two write requesters and drives one SETUP/PULSE/HOLD/SETTLE
// bus cycle per granted byte. Clear and home commands get the long settle time.
module lcd_bus_scheduler #(
    parameter int unsigned EN_CYCLES  = 25,
    parameter int unsigned CMD_WAIT   = 2500,
    parameter int unsigned CLR_WAIT   = 100000,
    parameter int unsigned PWRUP_WAIT = 750000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       req0,
    input  logic       req0_rs,
    input  logic [7:0] req0_byte,
    output logic       ack0,
    input  logic       req1,
    input  logic       req1_rs,
    input  logic [7:0] req1_byte,
    output logic       ack1,
    output logic       ready,
    output logic       busy,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic       lcd_rw
);

    // Terminal counts: each phase lasts N cycles, so the counter runs 0 .. N-1.
    localparam logic [23:0] EnLim  = 24'(EN_CYCLES - 1);
    localparam logic [23:0] CmdLim = 24'(CMD_WAIT - 1);
    localparam logic [23:0] ClrLim = 24'(CLR_WAIT - 1);
    localparam logic [23:0] PwrLim = 24'(PWRUP_WAIT - 1);

    typedef enum logic [2:0] {
        StPwrWait,
        StSetup,
        StPulse,
        StHold,
        StSettle,
        StIdle
    } state_e;

    state_e      state_q;
    logic [23:0] cnt_q;
    logic [1:0]  init_idx_q;
    logic        ready_q;
    logic        last_q;      // requester granted most recently
    logic [7:0]  lcd_data_q;
    logic        lcd_rs_q;
    logic        lcd_en_q;

    logic        can_grant;
    logic        grant0;
    logic        grant1;
    logic        clear_cmd;
    logic [23:0] settle_lim;

    // Init command table, indexed by position in the sequence.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = 8'h38;
            2'd1:    cmd = 8'h0C;
            2'd2:    cmd = 8'h06;
            default: cmd = 8'h01;
        endcase
        return cmd;
    endfunction

    // Round-robin grant decode; ack is combinational so it lands in the request cycle.
    always_comb begin
        can_grant = (state_q == StIdle) && ready_q && !Reset;
        grant0    = can_grant && req0 && (!req1 || last_q);
        grant1    = can_grant && req1 && (!req0 || !last_q);
    end

    // Settle length follows the byte still held on the bus.
    always_comb begin
        clear_cmd  = !lcd_rs_q && ((lcd_data_q == 8'h01) || (lcd_data_q == 8'h02));
        settle_lim = clear_cmd ? ClrLim : CmdLim;
    end

    // Main sequencer: state, phase counter and all registered bus outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= StPwrWait;
            cnt_q      <= '0;
            init_idx_q <= '0;
            ready_q    <= 1'b0;
            last_q     <= 1'b1;
            lcd_data_q <= 8'h00;
            lcd_rs_q   <= 1'b0;
            lcd_en_q   <= 1'b0;
        end else begin
            case (state_q)
                StPwrWait: begin
                    if (cnt_q == PwrLim) begin
                        state_q    <= StSetup;
                        cnt_q      <= '0;
                        init_idx_q <= 2'd0;
                        lcd_data_q <= init_cmd(2'd0);
                        lcd_rs_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 24'd1;
                    end
                end
                StSetup: begin
                    state_q  <= StPulse;
                    cnt_q    <= '0;
                    lcd_en_q <= 1'b1;
                end
                StPulse: begin
                    if (cnt_q == EnLim) begin
                        state_q  <= StHold;
                        cnt_q    <= '0;
                        lcd_en_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 24'd1;
                    end
                end
                StHold: begin
                    state_q <= StSettle;
                    cnt_q   <= '0;
                end
                StSettle: begin
                    if (cnt_q == settle_lim) begin
                        cnt_q <= '0;
                        // During init, chain straight into the next command.
                        if (!ready_q && (init_idx_q != 2'd3)) begin
                            state_q    <= StSetup;
                            init_idx_q <= init_idx_q + 2'd1;
                            lcd_data_q <= init_cmd(init_idx_q + 2'd1);
                            lcd_rs_q   <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 24'd1;
                    end
                end
                StIdle: begin
                    if (grant0) begin
                        state_q    <= StSetup;
                        cnt_q      <= '0;
                        lcd_data_q <= req0_byte;
                        lcd_rs_q   <= req0_rs;
                        last_q     <= 1'b0;
                    end else if (grant1) begin
                        state_q    <= StSetup;
                        cnt_q      <= '0;
                        lcd_data_q <= req1_byte;
                        lcd_rs_q   <= req1_rs;
                        last_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StPwrWait;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign ack0     = grant0;
    assign ack1     = grant1;
    assign ready    = ready_q;
    assign busy     = (state_q != StIdle);
    assign lcd_data = lcd_data_q;
    assign lcd_rs   = lcd_rs_q;
    assign lcd_en   = lcd_en_q;
    assign lcd_rw   = 1'b0;

    // Strobe only inside PULSE, and never two grants at once.
    a_en_in_pulse : assert property (@(posedge Clock) lcd_en_q |-> (state_q == StPulse));
    a_one_ack     : assert property (@(posedge Clock) !(ack0 && ack1));

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Bench for lcd_bus_scheduler: directed scenarios plus random traffic, all
// checked against a transaction-level timing model of the bus.
module tb_lcd_bus_scheduler;

    localparam int EN  = 2;
    localparam int CMD = 4;
    localparam int CLR = 8;
    localparam int PWR = 10;
    localparam int INIT_DONE = PWR + 3 * (2 + EN + CMD) + 3 + EN + CLR;
    localparam logic [7:0] INIT_CMDS [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req0_rs = 1'b0, req1 = 1'b0, req1_rs = 1'b0;
    logic [7:0] req0_byte = 8'h00, req1_byte = 8'h00;
    logic       ack0, ack1, ready, busy, lcd_rs, lcd_en, lcd_rw;
    logic [7:0] lcd_data;

    always #5 clk = ~clk;

    lcd_bus_scheduler #(
        .EN_CYCLES (EN),
        .CMD_WAIT  (CMD),
        .CLR_WAIT  (CLR),
        .PWRUP_WAIT(PWR)
    ) dut (
        .Clock    (clk),
        .Reset    (rst),
        .req0     (req0),
        .req0_rs  (req0_rs),
        .req0_byte(req0_byte),
        .ack0     (ack0),
        .req1     (req1),
        .req1_rs  (req1_rs),
        .req1_byte(req1_byte),
        .ack1     (ack1),
        .ready    (ready),
        .busy     (busy),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_en   (lcd_en),
        .lcd_rw   (lcd_rw)
    );

    // Model: every bus write (init or granted) is a transaction started at
    // "grant" cycle t; SETUP at t+1, strobe t+2..t+1+EN, bus held until the next.
    typedef struct {
        int         t;
        logic       rs;
        logic [7:0] b;
    } tx_s;

    tx_s  txq[$];
    int   cyc = 0;
    int   free_at = 1 << 30;
    int   ready_at = 1 << 30;
    int   last_rst = 0;
    bit   last_ptr = 1'b1;
    logic exp_ack0, exp_ack1, exp_en, exp_busy, exp_ready, exp_rs;
    logic [7:0] exp_data;
    int   n_checks = 0;
    int   n_pass = 0;

    function automatic int settle_of(logic rs, logic [7:0] b);
        if (!rs && (b == 8'h01 || b == 8'h02)) return CLR;
        return CMD;
    endfunction

    task automatic push_tx(int t, logic rs, logic [7:0] b);
        tx_s e;
        e.t = t; e.rs = rs; e.b = b;
        txq.push_back(e);
        while (txq.size() > 8) void'(txq.pop_front());
    endtask

    task automatic model_restart(int r);
        int t = r + PWR;
        txq.delete();
        last_ptr = 1'b1;
        last_rst = r;
        for (int i = 0; i < 4; i++) begin
            push_tx(t, 1'b0, INIT_CMDS[i]);
            if (i < 3) t = t + 2 + EN + settle_of(1'b0, INIT_CMDS[i]);
        end
        ready_at = t + 3 + EN + settle_of(1'b0, INIT_CMDS[3]);
        free_at  = ready_at;
    endtask

    task automatic model_eval();
        int k = -1;
        bit winner;
        exp_ack0 = 1'b0; exp_ack1 = 1'b0;
        exp_ready = (cyc >= ready_at);
        exp_busy  = (cyc < free_at);
        exp_data = 8'h00; exp_rs = 1'b0; exp_en = 1'b0;
        foreach (txq[i]) if (txq[i].t + 1 <= cyc) k = i;
        if (k >= 0) begin
            exp_data = txq[k].b;
            exp_rs   = txq[k].rs;
            exp_en   = (cyc >= txq[k].t + 2) && (cyc <= txq[k].t + 1 + EN);
        end
        if (rst) begin
            model_restart(cyc);
        end else if (cyc >= free_at && (req0 || req1)) begin
            if (req0 && req1) winner = last_ptr ? 1'b0 : 1'b1;
            else              winner = req0 ? 1'b0 : 1'b1;
            last_ptr = winner;
            if (!winner) begin
                exp_ack0 = 1'b1;
                push_tx(cyc, req0_rs, req0_byte);
                free_at = cyc + 3 + EN + settle_of(req0_rs, req0_byte);
            end else begin
                exp_ack1 = 1'b1;
                push_tx(cyc, req1_rs, req1_byte);
                free_at = cyc + 3 + EN + settle_of(req1_rs, req1_byte);
            end
        end
    endtask

    task automatic begin_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic end_cycle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic go_idle();
        int n = 0;
        begin_cycle(); req0 = 1'b0; req1 = 1'b0; end_cycle();
        while (cyc + 1 < free_at && n < 500) begin
            begin_cycle(); end_cycle(); n++;
        end
        n_checks++;
        if (n >= 500) $display("FAIL go_idle_bound cyc=%0d free_at=%0d", cyc, free_at);
        else n_pass++;
    endtask

    task automatic rand_req(output logic rs, output logic [7:0] b);
        case ($urandom_range(0, 3))
            0:       begin rs = 1'b0; b = 8'h01; end
            1:       begin rs = 1'b0; b = 8'h02; end
            default: begin rs = 1'($urandom_range(0, 1)); b = 8'($urandom_range(0, 255)); end
        endcase
    endtask

    task automatic test_reset();
        begin_cycle(); rst = 1'b1; req0 = 1'b0; req1 = 1'b0; end_cycle();
        begin_cycle(); rst = 1'b0; end_cycle();
        n_checks++;
        if (lcd_en !== 1'b0) $display("FAIL reset_en got=%b exp=0", lcd_en); else n_pass++;
        n_checks++;
        if (lcd_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", lcd_data); else n_pass++;
        n_checks++;
        if (lcd_rs !== 1'b0) $display("FAIL reset_rs got=%b exp=0", lcd_rs); else n_pass++;
        n_checks++;
        if (lcd_rw !== 1'b0) $display("FAIL reset_rw got=%b exp=0", lcd_rw); else n_pass++;
        n_checks++;
        if ({ack0, ack1} !== 2'b00) $display("FAIL reset_acks got=%b%b exp=00", ack0, ack1);
        else n_pass++;
        n_checks++;
        if (ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready); else n_pass++;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL reset_busy got=%b exp=1", busy); else n_pass++;
    endtask

    task automatic test_init_sequence();
        int         rises = 0;
        int         ack_at = -1;
        logic       prev_en = 1'b0;
        logic [7:0] seen[$];
        logic [7:0] want [5] = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h41};
        for (int i = 0; i < 60; i++) begin
            begin_cycle();
            if (i == 0) begin req1 = 1'b1; req1_rs = 1'b1; req1_byte = 8'h41; end
            if (ack_at >= 0) req1 = 1'b0;
            end_cycle();
            n_checks++;
            if ({ack0, ack1} !== {exp_ack0, exp_ack1})
                $display("FAIL init_acks cyc=%0d got=%b%b exp=%b%b", cyc, ack0, ack1,
                         exp_ack0, exp_ack1);
            else n_pass++;
            n_checks++;
            if (lcd_en !== exp_en) $display("FAIL init_en cyc=%0d got=%b exp=%b", cyc, lcd_en, exp_en);
            else n_pass++;
            n_checks++;
            if ({busy, ready} !== {exp_busy, exp_ready})
                $display("FAIL init_busy_ready cyc=%0d got=%b%b exp=%b%b", cyc, busy, ready,
                         exp_busy, exp_ready);
            else n_pass++;
            n_checks++;
            if ({lcd_rs, lcd_data} !== {exp_rs, exp_data})
                $display("FAIL init_bus cyc=%0d got=%b/%h exp=%b/%h", cyc, lcd_rs, lcd_data,
                         exp_rs, exp_data);
            else n_pass++;
            if (lcd_en === 1'b1 && prev_en !== 1'b1) begin rises++; seen.push_back(lcd_data); end
            prev_en = lcd_en;
            if (ack1 === 1'b1 && ack_at < 0) ack_at = cyc;
        end
        n_checks++;
        if (ack_at - last_rst != INIT_DONE)
            $display("FAIL init_first_ack got=%0d exp=%0d", ack_at - last_rst, INIT_DONE);
        else n_pass++;
        n_checks++;
        if (rises != 5) $display("FAIL init_pulse_count got=%0d exp=5", rises); else n_pass++;
        for (int i = 0; i < 5 && i < seen.size(); i++) begin
            n_checks++;
            if (seen[i] !== want[i]) $display("FAIL init_byte%0d got=%h exp=%h", i, seen[i], want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_single_write();
        int a[$];
        go_idle();
        for (int i = 0; i < 20; i++) begin
            begin_cycle(); req0 = 1'b1; req0_rs = 1'b1; req0_byte = 8'h48; end_cycle();
            n_checks++;
            if ({ack0, ack1, lcd_en} !== {exp_ack0, exp_ack1, exp_en})
                $display("FAIL single_ack_en cyc=%0d got=%b%b%b exp=%b%b%b", cyc, ack0, ack1,
                         lcd_en, exp_ack0, exp_ack1, exp_en);
            else n_pass++;
            if (ack0 === 1'b1) a.push_back(i);
        end
        n_checks++;
        if (a.size() < 2 || a[0] != 0 || a[1] - a[0] != 3 + EN + CMD)
            $display("FAIL single_spacing got_n=%0d got_first=%0d got_gap=%0d exp=0/%0d",
                     a.size(), (a.size() > 0) ? a[0] : -1, (a.size() > 1) ? a[1] - a[0] : -1,
                     3 + EN + CMD);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int acyc[$];
        bit who[$];
        go_idle();
        for (int i = 0; i < 40; i++) begin
            begin_cycle();
            req0 = 1'b1; req0_rs = 1'b1; req0_byte = 8'h30;
            req1 = 1'b1; req1_rs = 1'b1; req1_byte = 8'h31;
            end_cycle();
            n_checks++;
            if ({ack0, ack1} !== {exp_ack0, exp_ack1})
                $display("FAIL rr_acks cyc=%0d got=%b%b exp=%b%b", cyc, ack0, ack1,
                         exp_ack0, exp_ack1);
            else n_pass++;
            n_checks++;
            if (ack0 === 1'b1 && ack1 === 1'b1) $display("FAIL rr_both cyc=%0d got=11 exp=not 11", cyc);
            else n_pass++;
            if (ack0 === 1'b1 || ack1 === 1'b1) begin acyc.push_back(cyc); who.push_back(ack1); end
        end
        n_checks++;
        if (acyc.size() < 4) $display("FAIL rr_count got=%0d exp>=4", acyc.size()); else n_pass++;
        for (int i = 1; i < acyc.size(); i++) begin
            n_checks++;
            if (acyc[i] - acyc[i-1] != 3 + EN + CMD || who[i] == who[i-1])
                $display("FAIL rr_order idx=%0d got_gap=%0d got_who=%0d exp_gap=%0d exp_who=%0d",
                         i, acyc[i] - acyc[i-1], who[i], 3 + EN + CMD, !who[i-1]);
            else n_pass++;
        end
    endtask

    task automatic test_clear_settle();
        int t0 = -1;
        int next = -1;
        go_idle();
        begin_cycle(); req0 = 1'b1; req0_rs = 1'b0; req0_byte = 8'h01; end_cycle();
        t0 = cyc;
        n_checks++;
        if ({ack0, ack1} !== 2'b10) $display("FAIL clr_ack got=%b%b exp=10", ack0, ack1);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            begin_cycle(); req0 = 1'b0; req1 = 1'b1; req1_rs = 1'b1; req1_byte = 8'h55; end_cycle();
            n_checks++;
            if ({ack0, ack1, lcd_en} !== {exp_ack0, exp_ack1, exp_en})
                $display("FAIL clr_ack_en cyc=%0d got=%b%b%b exp=%b%b%b", cyc, ack0, ack1, lcd_en,
                         exp_ack0, exp_ack1, exp_en);
            else n_pass++;
            if (ack1 === 1'b1 && next < 0) next = cyc;
        end
        n_checks++;
        if (next - t0 != 3 + EN + CLR)
            $display("FAIL clr_next_ack got=%0d exp=%0d", next - t0, 3 + EN + CLR);
        else n_pass++;
    endtask

    task automatic test_withdraw();
        int acks = 0;
        go_idle();
        for (int i = 0; i < 15; i++) begin
            begin_cycle();
            req0 = (i == 0); req0_rs = 1'b1; req0_byte = 8'h48;
            req1 = (i >= 3 && i <= 6); req1_rs = 1'b1; req1_byte = 8'h77;
            end_cycle();
            n_checks++;
            if ({ack0, ack1} !== {exp_ack0, exp_ack1})
                $display("FAIL wd_acks cyc=%0d got=%b%b exp=%b%b", cyc, ack0, ack1,
                         exp_ack0, exp_ack1);
            else n_pass++;
            acks += int'(ack0 === 1'b1) + int'(ack1 === 1'b1);
        end
        n_checks++;
        if (acks != 1) $display("FAIL wd_total_acks got=%0d exp=1", acks); else n_pass++;
    endtask

    task automatic test_reset_midpulse();
        int   rise = -1;
        int   first_ack = -1;
        logic prev_en = 1'b0;
        go_idle();
        begin_cycle(); req0 = 1'b1; req0_rs = 1'b1; req0_byte = 8'h33; end_cycle();
        n_checks++;
        if (ack0 !== 1'b1) $display("FAIL rstmid_ack got=%b exp=1", ack0); else n_pass++;
        begin_cycle(); req0 = 1'b0; end_cycle();
        begin_cycle(); rst = 1'b1; end_cycle();
        n_checks++;
        if (lcd_en !== 1'b1) $display("FAIL rstmid_en_before got=%b exp=1", lcd_en); else n_pass++;
        begin_cycle(); rst = 1'b0; req0 = 1'b1; end_cycle();
        n_checks++;
        if ({lcd_en, ready, busy} !== 3'b001)
            $display("FAIL rstmid_after got=%b%b%b exp=001", lcd_en, ready, busy);
        else n_pass++;
        for (int i = 0; i < 55; i++) begin
            begin_cycle();
            if (first_ack >= 0) req0 = 1'b0;
            end_cycle();
            n_checks++;
            if ({ack0, ack1, lcd_en, lcd_rs, lcd_data} !==
                {exp_ack0, exp_ack1, exp_en, exp_rs, exp_data})
                $display("FAIL rstmid_bus cyc=%0d got=%b%b%b %b/%h exp=%b%b%b %b/%h", cyc, ack0,
                         ack1, lcd_en, lcd_rs, lcd_data, exp_ack0, exp_ack1, exp_en, exp_rs,
                         exp_data);
            else n_pass++;
            if (lcd_en === 1'b1 && prev_en !== 1'b1 && rise < 0) rise = cyc;
            prev_en = lcd_en;
            if (ack0 === 1'b1 && first_ack < 0) first_ack = cyc;
        end
        n_checks++;
        if (rise - last_rst != PWR + 2)
            $display("FAIL rstmid_restart got=%0d exp=%0d", rise - last_rst, PWR + 2);
        else n_pass++;
        n_checks++;
        if (first_ack - last_rst != INIT_DONE)
            $display("FAIL rstmid_first_ack got=%0d exp=%0d", first_ack - last_rst, INIT_DONE);
        else n_pass++;
    endtask

    task automatic test_random();
        logic pa0 = 1'b0, pa1 = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            begin_cycle();
            rst = ($urandom_range(0, 499) == 0);
            if (req0 && pa0) req0 = 1'b0;
            else if (req0 && $urandom_range(0, 39) == 0) req0 = 1'b0;
            else if (!req0 && $urandom_range(0, 5) == 0) begin
                req0 = 1'b1; rand_req(req0_rs, req0_byte);
            end else if ($urandom_range(0, 9) == 0) rand_req(req0_rs, req0_byte);
            if (req1 && pa1) req1 = 1'b0;
            else if (req1 && $urandom_range(0, 39) == 0) req1 = 1'b0;
            else if (!req1 && $urandom_range(0, 5) == 0) begin
                req1 = 1'b1; rand_req(req1_rs, req1_byte);
            end else if ($urandom_range(0, 9) == 0) rand_req(req1_rs, req1_byte);
            end_cycle();
            n_checks++;
            if ({ack0, ack1} !== {exp_ack0, exp_ack1})
                $display("FAIL rand_acks cyc=%0d got=%b%b exp=%b%b", cyc, ack0, ack1,
                         exp_ack0, exp_ack1);
            else n_pass++;
            n_checks++;
            if (lcd_en !== exp_en) $display("FAIL rand_en cyc=%0d got=%b exp=%b", cyc, lcd_en, exp_en);
            else n_pass++;
            n_checks++;
            if ({busy, ready} !== {exp_busy, exp_ready})
                $display("FAIL rand_busy_ready cyc=%0d got=%b%b exp=%b%b", cyc, busy, ready,
                         exp_busy, exp_ready);
            else n_pass++;
            n_checks++;
            if ({lcd_rs, lcd_data} !== {exp_rs, exp_data})
                $display("FAIL rand_bus cyc=%0d got=%b/%h exp=%b/%h", cyc, lcd_rs, lcd_data,
                         exp_rs, exp_data);
            else n_pass++;
            pa0 = ack0; pa1 = ack1;
        end
        begin_cycle(); rst = 1'b0; req0 = 1'b0; req1 = 1'b0; end_cycle();
    endtask

    initial begin
        test_reset();
        test_init_sequence();
        test_single_write();
        test_round_robin();
        test_clear_settle();
        test_withdraw();
        test_reset_midpulse();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lcd_bus_scheduler.md
LCD_BUS_SCHEDULER -- requirements
Module: lcd_bus_scheduler

Parameters (name, default, meaning)
- EN_CYCLES, 25: lcd_en high time in Clock cycles; must be at least 1.
- CMD_WAIT, 2500: settle cycles after a normal command or data write; must be at least 1.
- CLR_WAIT, 100000: settle cycles after command 0x01 (clear) or 0x02 (home); must be at least 1.
- PWRUP_WAIT, 750000: cycles to wait after reset before the first init command; must be at least 1.
- All parameter values must fit in the 24-bit internal counter.

Interface (name, direction, width, meaning)
REQ-001 Clock  in  1  single system clock; all state changes on its rising edge.
REQ-002 Reset  in  1  synchronous, active-high reset.
REQ-003 req0  in  1  requester 0 write request; held high until ack0.
REQ-004 req0_rs  in  1  requester 0 register select (0 = command, 1 = data).
REQ-005 req0_byte  in  8  requester 0 byte to write.
REQ-006 ack0  out  1  one-cycle grant; req0_rs/req0_byte are captured in this cycle.
REQ-007 req1, req1_rs, req1_byte, ack1: same as REQ-003..006 for requester 1.
REQ-008 ready  out  1  high once the init sequence is complete.
REQ-009 busy  out  1  high whenever the state is not IDLE.
REQ-010 lcd_data  out  8  LCD data bus.
REQ-011 lcd_rs  out  1  LCD register select.
REQ-012 lcd_en  out  1  LCD enable strobe.
REQ-013 lcd_rw  out  1  tied to 0 (write only).

Function
REQ-014 State machine:
- States are PWR_WAIT, SETUP, PULSE, HOLD, SETTLE, IDLE.
- Reset enters PWR_WAIT.
REQ-015 PWR_WAIT:
- Lasts PWRUP_WAIT cycles, then goes to SETUP with the first init command.
REQ-016 Init sequence:
- Commands 0x38, 0x0C, 0x06, 0x01 are issued in that order, each with lcd_rs=0.
- Each command runs SETUP->PULSE->HOLD->SETTLE.
- After the SETTLE of the last command, the block enters IDLE and ready rises to 1.
- ready stays 1 until the next Reset.
REQ-017 Requests while ready=0 are never acknowledged.
REQ-018 Grant timing:
- In IDLE with ready=1 and at least one req high, exactly one ack is asserted for exactly that cycle (cycle T).
- The granted rs/byte are latched in cycle T.
REQ-019 Arbitration:
- If only one requester is high, it wins.
- If both are high, the requester not granted last wins (round robin).
- The last-grant pointer resets to 1, so req0 wins the first tie.
REQ-020 Transaction timing for a grant at cycle T:
- T+1: SETUP, lcd_data/lcd_rs driven, lcd_en=0.
- T+2 .. T+1+EN_CYCLES: PULSE, lcd_en=1.
- T+2+EN_CYCLES: HOLD, lcd_en=0, data still held.
- Then SETTLE for W cycles.
- IDLE at T+3+EN_CYCLES+W; the next ack is possible in that same cycle.
REQ-021 Settle length W:
- W = CLR_WAIT when rs=0 and byte is 0x01 or 0x02.
- Otherwise W = CMD_WAIT.
- The same rule applies to init commands.
REQ-022 Bus hold:
- lcd_data and lcd_rs are stable from SETUP through the end of HOLD.
- After HOLD they keep their last value until the next SETUP.
REQ-023 A req dropped before its ack is treated as withdrawn; no ack is generated for it.
REQ-024 req/rs/byte changes while not in IDLE have no effect on the current transaction.
REQ-025 busy=1 in every state except IDLE, including during init.
REQ-026 lcd_en is never high outside PULSE; ack0 and ack1 are never high in the same cycle.

Reset
REQ-027 The following hold in the cycle after Reset is sampled high:
- lcd_en=0, lcd_data=0x00, lcd_rs=0, lcd_rw=0.
- ack0=ack1=0, ready=0, busy=1.
- Counter=0, last-grant pointer=1, state PWR_WAIT.
REQ-028 Reset asserted mid-transaction (any state) aborts it immediately; lcd_en=0 next cycle.
REQ-029 After a mid-transaction reset, the full PWR_WAIT and init sequence repeats; no ack is issued for the aborted request.

Verification (EN_CYCLES=2, CMD_WAIT=4, CLR_WAIT=8, PWRUP_WAIT=10)
- Release Reset, no requests -> 10 idle cycles, then 4 lcd_en pulses (2 cycles each, rs=0) carrying 0x38, 0x0C, 0x06, 0x01; settle gaps of 4, 4, 4, 8 cycles; ready=1 and busy=0 on the following cycle.
- req1 high with 0x41 from release of Reset -> no ack1 until ready=1; ack1 in the first IDLE cycle; then lcd_rs=1, lcd_data=0x41, lcd_en high 2 cycles.
- After ready, req0 rs=1 byte 0x48 at T -> ack0 at T, lcd_en high T+2..T+3, HOLD T+4, SETTLE T+5..T+8, req0 held high gets next ack0 at T+9.
- req0 and req1 held high continuously after ready -> acks in order ack0, ack1, ack0, ack1, spaced 9 cycles apart; never both in one cycle.
- req0 rs=0 byte 0x01 acked at T -> SETTLE lasts 8 cycles; next ack no earlier than T+13.
- Reset pulsed for 1 cycle while lcd_en=1 -> lcd_en=0 and ready=0 next cycle; the init sequence restarts after 10 cycles; the aborted request gets no ack.
